// File: rtl/branch_resolve_unit_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_if
//
// Purpose
//   Groups the request and result handshakes of branch_resolve_unit into a
//   single bundle.
//
// Signals
//   Request (front end -> unit)
//     in_valid     request present
//     in_ready     unit accepts the request this cycle
//     rs1_data     first compare operand, also the JALR base
//     rs2_data     second compare operand
//     branch_op    000 BEQ, 001 BNE, 010 BLT, 011 BGE,
//                  100 BLTU, 101 BGEU, 110 JAL, 111 JALR
//     pc           instruction PC
//     imm          sign-extended offset
//     pred_taken   front-end direction prediction
//     pred_target  front-end target prediction
//   Result (unit -> consumer)
//     out_valid    result present
//     out_ready    consumer accepts the result this cycle
//     taken        resolved direction
//     target       resolved target address
//     next_pc      address of the next instruction to fetch
//     mispredict   prediction did not match the resolution
//
// Modports
//   master  the side that issues requests and consumes results
//   slave   the branch resolve unit itself
// ----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);

  // Request channel
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  // Result channel
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            mispredict;

  modport master (
    output in_valid,
    output rs1_data,
    output rs2_data,
    output branch_op,
    output pc,
    output imm,
    output pred_taken,
    output pred_target,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  taken,
    input  target,
    input  next_pc,
    input  mispredict
  );

  modport slave (
    input  in_valid,
    input  rs1_data,
    input  rs2_data,
    input  branch_op,
    input  pc,
    input  imm,
    input  pred_taken,
    input  pred_target,
    input  out_ready,
    output in_ready,
    output out_valid,
    output taken,
    output target,
    output next_pc,
    output mispredict
  );

endinterface

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose
//   Resolves conditional branches and JAL/JALR jumps in a two-stage,
//   fully pipelined datapath with valid/ready handshakes on both sides.
//     S1 : evaluates the compare and the target address, registers them
//          together with the prediction and the PC.
//     S2 : forms next_pc and the mispredict flag, registers the result.
//   An accepted request shows up on out_valid exactly two cycles later when
//   the output is not back-pressured; one request per cycle is sustained
//   while out_ready stays high.
//
// Parameters
//   XLEN   operand / PC / immediate / target width (default 32)
//   CNT_W  performance counter width (default 32)
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   bus            branch_resolve_unit_if.slave (request + result handshakes)
//   flush          kills both pipeline stages and the input of this cycle
//   perf_clr       zeroes the performance counters
//   br_count       number of results handed over (saturating)
//   mispred_count  number of mispredicting results handed over (saturating)
//
// Configuration
//   BRU_PERF_CNT_EN  defined   : saturating br_count / mispred_count exist.
//                    undefined : no counter state, both outputs read 0 and
//                                perf_clr has no effect.
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus,
  input  logic                 flush,
  input  logic                 perf_clr,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  // --------------------------------------------------------------------------
  // Operation encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b010;
  localparam logic [2:0] OP_BGE  = 3'b011;
  localparam logic [2:0] OP_BLTU = 3'b100;
  localparam logic [2:0] OP_BGEU = 3'b101;
  localparam logic [2:0] OP_JAL  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  // S1
  logic            s1_valid_reg;
  logic            s1_taken_reg;
  logic [XLEN-1:0] s1_target_reg;
  logic [XLEN-1:0] s1_pc_reg;
  logic            s1_pred_taken_reg;
  logic [XLEN-1:0] s1_pred_target_reg;

  // S2 (drives the result channel directly)
  logic            out_valid_reg;
  logic            taken_reg;
  logic [XLEN-1:0] target_reg;
  logic [XLEN-1:0] next_pc_reg;
  logic            mispredict_reg;

  // --------------------------------------------------------------------------
  // Handshake / stall control
  // --------------------------------------------------------------------------
  logic s2_adv;
  logic s1_adv;
  logic in_ready_int;
  logic in_fire;

  // S2 may load whenever its current content leaves or it is empty.
  assign s2_adv = ~out_valid_reg | bus.out_ready;
  // S1 may load whenever it is empty or its content moves into S2.
  assign s1_adv = ~s1_valid_reg | s2_adv;

  // Reset and flush both block acceptance; a request offered in a flush
  // cycle is therefore never taken.
  assign in_ready_int = ~rst & ~flush & s1_adv;
  assign in_fire      = bus.in_valid & in_ready_int;

  assign bus.in_ready = in_ready_int;

  // --------------------------------------------------------------------------
  // S1 combinational: compare and target
  // --------------------------------------------------------------------------
  logic            op_eq;
  logic            op_lt_s;
  logic            op_lt_u;
  logic            taken_next;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] rs1_sum;
  logic [XLEN-1:0] target_next;

  assign op_eq   = (bus.rs1_data == bus.rs2_data);
  assign op_lt_s = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
  assign op_lt_u = (bus.rs1_data < bus.rs2_data);

  always_comb begin
    taken_next = 1'b0;
    case (bus.branch_op)
      OP_BEQ:  taken_next = op_eq;
      OP_BNE:  taken_next = ~op_eq;
      OP_BLT:  taken_next = op_lt_s;
      OP_BGE:  taken_next = ~op_lt_s;
      OP_BLTU: taken_next = op_lt_u;
      OP_BGEU: taken_next = ~op_lt_u;
      OP_JAL:  taken_next = 1'b1;
      OP_JALR: taken_next = 1'b1;
      default: taken_next = 1'b0;
    endcase
  end

  // Both sums wrap naturally at XLEN bits.
  assign pc_sum  = bus.pc + bus.imm;
  assign rs1_sum = bus.rs1_data + bus.imm;

  // JALR clears bit 0 of its computed address; everything else is PC-relative.
  assign target_next = (bus.branch_op == OP_JALR) ? {rs1_sum[XLEN-1:1], 1'b0}
                                                  : pc_sum;

  // --------------------------------------------------------------------------
  // S2 combinational: next PC and mispredict
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] next_pc_next;
  logic            target_miss;
  logic            mispredict_next;

  assign next_pc_next = s1_taken_reg ? s1_target_reg : (s1_pc_reg + PC_STEP);
  assign target_miss  = (s1_pred_target_reg != s1_target_reg);

  // One expression covers both branch classes: jumps are always taken, so
  // the direction term collapses to !pred_taken and the target term to
  // pred_taken && target_miss, i.e. !pred_taken || target_miss overall.
  assign mispredict_next = (s1_taken_reg ^ s1_pred_taken_reg) |
                           (s1_taken_reg & s1_pred_taken_reg & target_miss);

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg       <= 1'b0;
      s1_taken_reg       <= 1'b0;
      s1_target_reg      <= '0;
      s1_pc_reg          <= '0;
      s1_pred_taken_reg  <= 1'b0;
      s1_pred_target_reg <= '0;
      out_valid_reg      <= 1'b0;
      taken_reg          <= 1'b0;
      target_reg         <= '0;
      next_pc_reg        <= '0;
      mispredict_reg     <= 1'b0;
    end else if (flush) begin
      // Only the valids are dropped; stale payload is harmless.
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      // S2: payload only changes when a new result actually moves in, so a
      // stalled result (out_valid && !out_ready) stays bit-for-bit stable.
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          taken_reg      <= s1_taken_reg;
          target_reg     <= s1_target_reg;
          next_pc_reg    <= next_pc_next;
          mispredict_reg <= mispredict_next;
        end
      end

      // S1
      if (s1_adv) begin
        s1_valid_reg <= in_fire;
        if (in_fire) begin
          s1_taken_reg       <= taken_next;
          s1_target_reg      <= target_next;
          s1_pc_reg          <= bus.pc;
          s1_pred_taken_reg  <= bus.pred_taken;
          s1_pred_target_reg <= bus.pred_target;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.taken      = taken_reg;
  assign bus.target     = target_reg;
  assign bus.next_pc    = next_pc_reg;
  assign bus.mispredict = mispredict_reg;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       out_fire;
  logic [1:0] cnt_inc;

  // A result offered during a flush is not considered handed over.
  assign out_fire   = out_valid_reg & bus.out_ready & ~flush;
  assign cnt_inc[0] = out_fire;
  assign cnt_inc[1] = out_fire & mispredict_reg;

  // Index 0 counts all results, index 1 only the mispredicting ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (perf_clr) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign br_count      = g_cnt[0].cnt_reg;
  assign mispred_count = g_cnt[1].cnt_reg;
`else
  // Counters compiled out: outputs read zero and perf_clr goes nowhere.
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;

  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit (XLEN=32, CNT_W=4).
// A table of directed vectors with hand-computed results is pushed through
// one at a time, followed by hand-written sequences for backpressure, flush,
// counter saturation / clear and mid-flight reset. Counter expectations
// follow BRU_PERF_CNT_EN: without it both counters must read 0.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b010;
  localparam logic [2:0] OP_BGE  = 3'b011;
  localparam logic [2:0] OP_BLTU = 3'b100;
  localparam logic [2:0] OP_BGEU = 3'b101;
  localparam logic [2:0] OP_JAL  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  localparam int NVEC = 15;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken;
    logic [31:0] e_target;
    logic [31:0] e_npc;
    logic        e_misp;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;
  logic perf_clr;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .flush         (flush),
    .perf_clr      (perf_clr),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_br = 0;
  int   m_mp = 0;
  vec_t vecs [NVEC];

  // Hard stop in case something hangs despite the bounded loops.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Expected counter value for a given number of events.
  function automatic logic [31:0] ecnt(input int v);
`ifdef BRU_PERF_CNT_EN
    return (v > 15) ? 32'd15 : 32'(v);
`else
    return (v > 15) ? 32'd0 : 32'd0 + 32'(v) * 32'd0;
`endif
  endfunction

  task automatic chk_counters(input string tag);
    chk32({tag, "_br_count"}, 32'(br_count), ecnt(m_br));
    chk32({tag, "_mispred_count"}, 32'(mispred_count), ecnt(m_mp));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int i);
    bus.branch_op   = vecs[i].op;
    bus.rs1_data    = vecs[i].rs1;
    bus.rs2_data    = vecs[i].rs2;
    bus.pc          = vecs[i].pc;
    bus.imm         = vecs[i].imm;
    bus.pred_taken  = vecs[i].pt;
    bus.pred_target = vecs[i].ptgt;
  endtask

  task automatic chk_result(input string tag, input int i);
    chk1 ({tag, "_taken"},      bus.taken,      vecs[i].e_taken);
    chk32({tag, "_target"},     bus.target,     vecs[i].e_target);
    chk32({tag, "_next_pc"},    bus.next_pc,    vecs[i].e_npc);
    chk1 ({tag, "_mispredict"}, bus.mispredict, vecs[i].e_misp);
    $display("%s vec %0d op=%0d taken=%b target=0x%08h next_pc=0x%08h mispredict=%b",
             tag, i, vecs[i].op, bus.taken, bus.target, bus.next_pc, bus.mispredict);
  endtask

  // Single request with out_ready high: checks acceptance, the 2-cycle
  // latency and the resolved result; the result transfers on the last edge.
  task automatic apply_vec(input int i);
    drive_vec(i);
    bus.in_valid = 1'b1;
    #1 chk1("vec_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    #1 chk1("vec_latency1_out_valid", bus.out_valid, 1'b0);
    tick();
    #1 chk1("vec_latency2_out_valid", bus.out_valid, 1'b1);
    chk_result("vec", i);
    m_br++;
    if (vecs[i].e_misp) m_mp++;
    tick();
  endtask

  task automatic pulse_perf_clr();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    m_br = 0;
    m_mp = 0;
  endtask

  initial begin
    //             op       rs1            rs2            pc             imm            pt    ptgt          taken target        next_pc       misp
    vecs[0]  = '{OP_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0120, 32'h0000_0120, 1'b1};
    vecs[1]  = '{OP_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0100, 32'h0000_0020, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0120, 32'h0000_0104, 1'b0};
    vecs[2]  = '{OP_JALR, 32'h0000_1003, 32'h0000_0000, 32'h0000_0050, 32'h0000_0004, 1'b1, 32'h0000_1006, 1'b1, 32'h0000_1006, 32'h0000_1006, 1'b0};
    vecs[3]  = '{OP_JALR, 32'h0000_1003, 32'h0000_0000, 32'h0000_0050, 32'h0000_0004, 1'b1, 32'h0000_1004, 1'b1, 32'h0000_1006, 32'h0000_1006, 1'b1};
    vecs[4]  = '{OP_BEQ,  32'h0000_0005, 32'h0000_0005, 32'h0000_0200, 32'hFFFF_FFF0, 1'b1, 32'h0000_01F0, 1'b1, 32'h0000_01F0, 32'h0000_01F0, 1'b0};
    vecs[5]  = '{OP_BNE,  32'h0000_0005, 32'h0000_0005, 32'h0000_0200, 32'h0000_0008, 1'b1, 32'h0000_0208, 1'b0, 32'h0000_0208, 32'h0000_0204, 1'b1};
    vecs[6]  = '{OP_BGE,  32'h8000_0000, 32'h0000_0000, 32'h0000_0300, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0340, 32'h0000_0304, 1'b0};
    vecs[7]  = '{OP_BGEU, 32'h8000_0000, 32'h0000_0000, 32'h0000_0300, 32'h0000_0040, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0340, 32'h0000_0340, 1'b1};
    vecs[8]  = '{OP_BLT,  32'h0000_0001, 32'h0000_0002, 32'h0000_0400, 32'h0000_0010, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0410, 32'h0000_0410, 1'b1};
    vecs[9]  = '{OP_JAL,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b0};
    vecs[10] = '{OP_BEQ,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 32'h0000_0000, 1'b0};
    vecs[11] = '{OP_JAL,  32'h0000_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0100, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0110, 32'h0000_0110, 1'b1};
    vecs[12] = '{OP_BLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0004, 1'b1, 32'h0000_0024, 1'b1, 32'h0000_0024, 32'h0000_0024, 1'b0};
    vecs[13] = '{OP_JALR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0060, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{OP_BGE,  32'h0000_0007, 32'h0000_0007, 32'h0000_0500, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_04FC, 32'h0000_04FC, 1'b1};

    rst           = 1'b1;
    flush         = 1'b0;
    perf_clr      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_vec(0);

    // ---------------- reset ----------------
    tick();
    tick();
    chk1 ("rst_in_ready",      bus.in_ready,   1'b0);
    chk1 ("rst_out_valid",     bus.out_valid,  1'b0);
    chk1 ("rst_taken",         bus.taken,      1'b0);
    chk32("rst_target",        bus.target,     32'h0);
    chk32("rst_next_pc",       bus.next_pc,    32'h0);
    chk1 ("rst_mispredict",    bus.mispredict, 1'b0);
    chk_counters("rst");
    rst = 1'b0;
    #1 chk1("rst_release_in_ready", bus.in_ready, 1'b1);

    // ---------------- directed vectors ----------------
    for (int i = 0; i < NVEC; i++) apply_vec(i);
    #1 chk_counters("vectors");

    pulse_perf_clr();
    #1 chk_counters("clear1");

    // ---------------- backpressure ----------------
    begin
      int          idx;
      int          got;
      logic        prev_hold;
      logic        h_taken;
      logic [31:0] h_target;
      logic [31:0] h_npc;
      logic        h_misp;
      idx       = 0;
      got       = 0;
      prev_hold = 1'b0;
      h_taken   = 1'b0;
      h_target  = '0;
      h_npc     = '0;
      h_misp    = 1'b0;
      for (int c = 0; c < 30 && got < 4; c++) begin
        if (idx < 4) begin
          drive_vec(idx);
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
        bus.out_ready = (c < 2 || c > 5);
        #1;
        if (c < 2)             chk1("bp_in_ready_open",  bus.in_ready, 1'b1);
        if (c >= 2 && c <= 5)  chk1("bp_in_ready_stall", bus.in_ready, 1'b0);
        if (prev_hold) begin
          chk1 ("bp_hold_out_valid",  bus.out_valid,  1'b1);
          chk1 ("bp_hold_taken",      bus.taken,      h_taken);
          chk32("bp_hold_target",     bus.target,     h_target);
          chk32("bp_hold_next_pc",    bus.next_pc,    h_npc);
          chk1 ("bp_hold_mispredict", bus.mispredict, h_misp);
        end
        if (bus.out_valid && bus.out_ready) begin
          chk_result("bp", got);
          m_br++;
          if (vecs[got].e_misp) m_mp++;
          got++;
        end
        prev_hold = bus.out_valid & ~bus.out_ready;
        h_taken   = bus.taken;
        h_target  = bus.target;
        h_npc     = bus.next_pc;
        h_misp    = bus.mispredict;
        if (bus.in_valid && bus.in_ready) idx++;
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk32("bp_results", 32'(got), 32'd4);
      #1 chk_counters("bp");
    end

    // ---------------- flush ----------------
    bus.out_ready = 1'b0;
    drive_vec(4);
    bus.in_valid = 1'b1;
    tick();
    drive_vec(5);
    tick();
    drive_vec(6);
    #1 chk1("flush_pre_out_valid", bus.out_valid, 1'b1);
    chk1("flush_pre_in_ready", bus.in_ready, 1'b0);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk1("flush_in_ready", bus.in_ready, 1'b0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk1("flush_out_valid_next", bus.out_valid, 1'b0);
    chk_counters("flush");
    tick();
    tick();
    tick();
    chk1("flush_drained_out_valid", bus.out_valid, 1'b0);
    $display("flush sequence out_valid=%b br_count=%0d", bus.out_valid, br_count);

    // ---------------- saturation ----------------
    pulse_perf_clr();
    begin
      int sent;
      int got;
      sent = 0;
      got  = 0;
      drive_vec(0);
      for (int c = 0; c < 60 && got < 17; c++) begin
        bus.in_valid = (sent < 17);
        #1;
        if (bus.out_valid && bus.out_ready) begin
          chk1("sat_mispredict", bus.mispredict, 1'b1);
          got++;
          m_br++;
          m_mp++;
          $display("sat result %0d br_count=%0d mispred_count=%0d", got, br_count, mispred_count);
        end
        if (bus.in_valid && bus.in_ready) sent++;
        tick();
      end
      bus.in_valid = 1'b0;
      chk32("sat_results", 32'(got), 32'd17);
      #1 chk_counters("sat");
    end

    // perf_clr in the same cycle as a transfer: the clear wins.
    drive_vec(0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    perf_clr = 1'b1;
    #1 chk1("clr_xfer_out_valid", bus.out_valid, 1'b1);
    tick();
    perf_clr = 1'b0;
    m_br = 0;
    m_mp = 0;
    #1 chk_counters("clr_xfer");

    // ---------------- mid-flight reset ----------------
    apply_vec(7);
    bus.out_ready = 1'b0;
    drive_vec(8);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    drive_vec(7);
    tick();
    #1 chk1("rst2_pre_out_valid", bus.out_valid, 1'b1);
    chk_counters("rst2_pre");
    rst = 1'b1;
    #1 chk1("rst2_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk1 ("rst2_out_valid",  bus.out_valid,  1'b0);
    chk1 ("rst2_taken",      bus.taken,      1'b0);
    chk32("rst2_target",     bus.target,     32'h0);
    chk32("rst2_next_pc",    bus.next_pc,    32'h0);
    chk1 ("rst2_mispredict", bus.mispredict, 1'b0);
    m_br = 0;
    m_mp = 0;
    chk_counters("rst2");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk1("rst2_release_in_ready", bus.in_ready, 1'b1);
    tick();
    tick();
    chk1("rst2_no_stale_out_valid", bus.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
